// File: rtl/i2c_audio_pkg.sv
// Shared types and constants for the write-only I2C codec-configuration responder.
// Holds the protocol FSM states, the slave address and the codec register-file power-on table.
package i2c_audio_pkg;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h1A;
    localparam logic [6:0] CODEC_RESET_REG  = 7'h0F;
    localparam int         NUM_REGS         = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_A,
        ST_BYTE1,
        ST_ACK_1,
        ST_BYTE2,
        ST_ACK_2,
        ST_DONE,
        ST_IGNORE
    } state_e;

    localparam logic [8:0] REG_DEFAULTS [NUM_REGS] = '{
        9'h097, 9'h097, 9'h079, 9'h079, 9'h00A, 9'h008, 9'h09F, 9'h00A,
        9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000
    };

    // Every ACK slot hands over to the state that receives the next byte.
    function automatic state_e ack_next_state(input state_e st);
        case (st)
            ST_ACK_A: return ST_BYTE1;
            ST_ACK_1: return ST_BYTE2;
            ST_ACK_2: return ST_DONE;
            default:  return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/i2c_bus_sync_edge.sv
// Brings the raw SCL/SDA pads into the clk domain and turns them into single-cycle
// SCL rise/fall, START and STOP events (pad-to-event latency SYNC_STAGES+1 cycles).
module i2c_bus_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;
    logic                   sda_s;

    // Chains reset to the idle-bus level so releasing reset cannot fake a START.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    assign sda_o      = sda_s;
    assign scl_rise_o = scl_s & ~scl_prev_q;
    assign scl_fall_o = ~scl_s & scl_prev_q;
    assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_audio_slave.sv
// Write-only I2C codec stand-in: decodes {dev+W, reg[6:0]&d8, data[7:0]} writes,
// ACKs them and commits 9-bit values into a 16-entry register file.
module i2c_audio_slave
    import i2c_audio_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = DEV_ADDR_DEFAULT,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       wr_valid,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       busy,
    output logic       err
);

    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_ev;
    logic stop_ev;

    i2c_bus_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .reset      (reset),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_ev),
        .stop_o     (stop_ev)
    );

    state_e      state_q,    state_d;
    logic [2:0]  bit_cnt_q,  bit_cnt_d;
    logic [6:0]  shift_q,    shift_d;
    logic        oe_q,       oe_d;
    logic [6:0]  reg_addr_q, reg_addr_d;
    logic        d8_q,       d8_d;
    logic        wr_valid_q, wr_valid_d;
    logic [6:0]  wr_addr_q,  wr_addr_d;
    logic [8:0]  wr_data_q,  wr_data_d;
    logic        err_q,      err_d;
    logic [8:0]  regs_q [NUM_REGS];

    logic [7:0]  byte_in;
    logic        byte_done;
    logic        partial;

    assign byte_in   = {shift_q, sda_s};
    assign byte_done = scl_rise && (bit_cnt_q == 3'd7);
    // Anything between START and the commit is an unfinished write.
    assign partial   = state_q inside {ST_ADDR, ST_ACK_A, ST_BYTE1, ST_ACK_1, ST_BYTE2};

    // NOTE: every always_comb output gets a default first, otherwise untaken branches infer latches.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        oe_d       = oe_q;
        reg_addr_d = reg_addr_q;
        d8_d       = d8_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        err_d      = err_q;

        if (stop_ev) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            oe_d      = 1'b0;
            if (partial) err_d = 1'b1;
        end else if (start_ev) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 3'd0;
            oe_d      = 1'b0;
            if (partial) err_d = 1'b1;
        end else begin
            case (state_q)
                ST_ADDR, ST_BYTE1, ST_BYTE2, ST_DONE: begin
                    if (scl_rise) begin
                        shift_d   = byte_in[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                    if (byte_done) begin
                        case (state_q)
                            ST_ADDR: begin
                                if (byte_in[7:1] == DEV_ADDR && !byte_in[0]) begin
                                    state_d = ST_ACK_A;
                                end else begin
                                    state_d = ST_IGNORE;
                                    err_d   = 1'b1;
                                end
                            end
                            ST_BYTE1: begin
                                reg_addr_d = byte_in[7:1];
                                d8_d       = byte_in[0];
                                state_d    = ST_ACK_1;
                            end
                            ST_BYTE2: begin
                                wr_valid_d = 1'b1;
                                wr_addr_d  = reg_addr_q;
                                wr_data_d  = {d8_q, byte_in};
                                state_d    = ST_ACK_2;
                            end
                            default: begin
                                state_d = ST_IGNORE;
                                err_d   = 1'b1;
                            end
                        endcase
                    end
                end
                // First SCL fall (end of bit 8) pulls SDA, second (end of ACK bit) releases it.
                ST_ACK_A, ST_ACK_1, ST_ACK_2: begin
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else begin
                            oe_d    = 1'b0;
                            state_d = ack_next_state(state_q);
                        end
                    end
                end
                ST_IGNORE: oe_d = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 7'd0;
            oe_q       <= 1'b0;
            reg_addr_q <= 7'd0;
            d8_q       <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 7'd0;
            wr_data_q  <= 9'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            oe_q       <= oe_d;
            reg_addr_q <= reg_addr_d;
            d8_q       <= d8_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            err_q      <= err_d;
        end
    end

    // NOTE: the register file is reset on purpose -- the datapath needs the codec defaults, not X.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= REG_DEFAULTS[i];
        end else if (wr_valid_d) begin
            if (wr_addr_d == CODEC_RESET_REG) begin
                for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= REG_DEFAULTS[i];
            end else if (wr_addr_d[6:4] == 3'd0) begin
                regs_q[wr_addr_d[3:0]] <= wr_data_d;
            end
        end
    end

    assign sda_oe   = oe_q;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign rd_data  = regs_q[rd_addr];
    assign busy     = (state_q != ST_IDLE);
    assign err      = err_q;

endmodule

// File: tb/tb_i2c_audio_slave.sv
// Directed bench for i2c_audio_slave: a bit-banged I2C master on an open-drain SDA,
// with hand-computed expectations for ACKs, commits, register contents and error flag.
module tb_i2c_audio_slave;

    localparam int Q = 8;  // clk cycles per SCL quarter period

    logic       clk;
    logic       reset;
    logic       scl;
    logic       sda_drv;
    logic       sda_bus;
    logic       sda_oe;
    logic       wr_valid;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    logic [3:0] rd_addr;
    logic [8:0] rd_data;
    logic       busy;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;
    int oe_cnt  = 0;
    logic [6:0] last_addr = '0;
    logic [8:0] last_data = '0;

    assign sda_bus = sda_drv & ~sda_oe;

    i2c_audio_slave #(
        .DEV_ADDR    (7'h1A),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .scl_i    (scl),
        .sda_i    (sda_bus),
        .sda_oe   (sda_oe),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_valid) begin
            wr_cnt    <= wr_cnt + 1;
            last_addr <= wr_addr;
            last_data <= wr_data;
        end
        if (sda_oe) oe_cnt <= oe_cnt + 1;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; wait_q();
        scl     = 1'b1; wait_q();
        sda_drv = 1'b0; wait_q();
        scl     = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; wait_q();
        scl     = 1'b1; wait_q();
        sda_drv = 1'b1; wait_q();
        wait_q();
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sda_drv = b[i]; wait_q();
            scl     = 1'b1; wait_q(); wait_q();
            scl     = 1'b0; wait_q();
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        sda_drv = 1'b1; wait_q();
        scl     = 1'b1; wait_q();
        ack     = sda_oe;
        wait_q();
        scl     = 1'b0; wait_q();
    endtask

    task automatic write3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          output logic [2:0] acks);
        i2c_start();
        send_byte(b0, acks[2]);
        send_byte(b1, acks[1]);
        send_byte(b2, acks[0]);
        i2c_stop();
        repeat (4) @(negedge clk);
    endtask

    task automatic check_reg(input string tag, input logic [3:0] a, input logic [8:0] exp);
        rd_addr = a;
        #1;
        check(tag, {23'd0, rd_data}, {23'd0, exp});
    endtask

    initial begin
        logic [2:0] acks;
        logic [3:0] acks4;
        int         wr0;
        int         oe0;

        reset = 1'b1; scl = 1'b1; sda_drv = 1'b1; rd_addr = 4'd0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_sda_oe",   {31'd0, sda_oe},   32'd0);
        check("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
        check("rst_wr_addr",  {25'd0, wr_addr},  32'd0);
        check("rst_wr_data",  {23'd0, wr_data},  32'd0);
        check("rst_busy",     {31'd0, busy},     32'd0);
        check("rst_err",      {31'd0, err},      32'd0);
        check_reg("rst_r0", 4'd0,  9'h097);
        check_reg("rst_r6", 4'd6,  9'h09F);
        check_reg("rst_r9", 4'd9,  9'h000);

        // Plain write: R2 <= {1, 0x7F}
        wr0 = wr_cnt;
        i2c_start();
        check("busy_after_start", {31'd0, busy}, 32'd1);
        send_byte(8'h34, acks[2]);
        send_byte(8'h05, acks[1]);
        send_byte(8'h7F, acks[0]);
        i2c_stop();
        repeat (4) @(negedge clk);
        check("w1_acks",    {29'd0, acks},    32'h7);
        check("w1_wr_cnt",  wr_cnt - wr0,     32'd1);
        check("w1_wr_addr", {25'd0, last_addr}, 32'h02);
        check("w1_wr_data", {23'd0, last_data}, 32'h17F);
        check_reg("w1_r2", 4'd2, 9'h17F);
        check("w1_busy",    {31'd0, busy},    32'd0);
        check("w1_err",     {31'd0, err},     32'd0);

        // R4 <= 0x016, then codec reset via register 0x0F
        write3(8'h34, 8'h08, 8'h16, acks);
        check("w2_acks", {29'd0, acks}, 32'h7);
        check_reg("w2_r4", 4'd4, 9'h016);
        wr0 = wr_cnt;
        write3(8'h34, 8'h1E, 8'h00, acks);
        check("crst_acks",    {29'd0, acks},      32'h7);
        check("crst_wr_cnt",  wr_cnt - wr0,       32'd1);
        check("crst_wr_addr", {25'd0, last_addr}, 32'h0F);
        check("crst_wr_data", {23'd0, last_data}, 32'h000);
        check_reg("crst_r4", 4'd4,  9'h00A);
        check_reg("crst_r0", 4'd0,  9'h097);
        check_reg("crst_r2", 4'd2,  9'h079);
        check_reg("crst_r15", 4'd15, 9'h000);
        check("crst_err", {31'd0, err}, 32'd0);

        // Wrong device address
        do_reset();
        wr0 = wr_cnt; oe0 = oe_cnt;
        write3(8'h36, 8'h05, 8'h7F, acks);
        check("badaddr_acks",   {29'd0, acks},  32'h0);
        check("badaddr_oe",     oe_cnt - oe0,   32'd0);
        check("badaddr_wr_cnt", wr_cnt - wr0,   32'd0);
        check("badaddr_err",    {31'd0, err},   32'd1);
        check_reg("badaddr_r2", 4'd2, 9'h079);

        // Read bit set
        do_reset();
        check("rst2_err", {31'd0, err}, 32'd0);
        wr0 = wr_cnt; oe0 = oe_cnt;
        write3(8'h35, 8'h05, 8'h7F, acks);
        check("rdbit_acks",   {29'd0, acks}, 32'h0);
        check("rdbit_oe",     oe_cnt - oe0,  32'd0);
        check("rdbit_wr_cnt", wr_cnt - wr0,  32'd0);
        check("rdbit_err",    {31'd0, err},  32'd1);
        check_reg("rdbit_r2", 4'd2, 9'h079);

        // STOP before BYTE2 discards the write; the next full write lands
        do_reset();
        wr0 = wr_cnt;
        i2c_start();
        send_byte(8'h34, acks[2]);
        send_byte(8'h12, acks[1]);
        i2c_stop();
        repeat (4) @(negedge clk);
        check("short_acks",   {30'd0, acks[2:1]}, 32'h3);
        check("short_wr_cnt", wr_cnt - wr0,       32'd0);
        check_reg("short_r9", 4'd9, 9'h000);
        check("short_err",    {31'd0, err},       32'd1);
        write3(8'h34, 8'h12, 8'h01, acks);
        check("after_short_acks",   {29'd0, acks}, 32'h7);
        check("after_short_wr_cnt", wr_cnt - wr0,  32'd1);
        check_reg("after_short_r9", 4'd9, 9'h001);

        // Extra fourth byte is NACKed
        do_reset();
        wr0 = wr_cnt;
        i2c_start();
        send_byte(8'h34, acks4[3]);
        send_byte(8'h05, acks4[2]);
        send_byte(8'h7F, acks4[1]);
        send_byte(8'hAA, acks4[0]);
        i2c_stop();
        repeat (4) @(negedge clk);
        check("extra_acks",   {28'd0, acks4}, 32'hE);
        check("extra_wr_cnt", wr_cnt - wr0,   32'd1);
        check("extra_err",    {31'd0, err},   32'd1);
        check_reg("extra_r2", 4'd2, 9'h17F);

        // Reset in the middle of BYTE2, then resume normally
        do_reset();
        wr0 = wr_cnt;
        i2c_start();
        send_byte(8'h34, acks[2]);
        send_byte(8'h07, acks[1]);
        send_bits(8'h02, 4);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("midrst_busy",   {31'd0, busy},   32'd0);
        check("midrst_err",    {31'd0, err},    32'd0);
        i2c_stop();
        repeat (4) @(negedge clk);
        check("midrst_wr_cnt", wr_cnt - wr0, 32'd0);
        check_reg("midrst_r7", 4'd7, 9'h00A);
        check_reg("midrst_r3", 4'd3, 9'h079);
        write3(8'h34, 8'h0E, 8'h55, acks);
        check("resume_acks",    {29'd0, acks},      32'h7);
        check("resume_wr_cnt",  wr_cnt - wr0,       32'd1);
        check("resume_wr_addr", {25'd0, last_addr}, 32'h07);
        check_reg("resume_r7", 4'd7, 9'h055);
        check("resume_err",     {31'd0, err},       32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
